play_ctrl: RTL
==============

// Module: play_ctrl
// PURPOSE
//   Upstream control stage for the LED chaser and tone player. Debounces the two
//   user push-buttons (PLAY, STOP) and runs a STOPPED/PLAYING/PAUSED state machine.
//   Drives the hold signal START (1 = freeze downstream timers) and a one-cycle
//   CLR pulse that restarts downstream position/timer logic from zero.
// PARAMETERS
//   DEBOUNCE_CYC  1000000  cycles an input must stay stable before accepted (20 ms @ 50 MHz); must be >= 2
// PORTS
//   CLK       in   1  system clock; all logic on posedge
//   RST       in   1  asynchronous, active-high reset
//   BTN_PLAY  in   1  raw play/pause button, active-high, asynchronous to CLK
//   BTN_STOP  in   1  raw stop button, active-high, asynchronous to CLK
//   START     out  1  hold to downstream: 1 = freeze (STOPPED/PAUSED), 0 = run (PLAYING)
//   CLR       out  1  one-cycle restart pulse to downstream timers
//   state     out  2  current FSM state: 00 STOPPED, 01 PLAYING, 10 PAUSED (11 unused)
// BEHAVIOUR
//   Reset (async, RST=1): state=00, START=1, CLR=0; synchronisers, debounce counters,
//     stable levels and edge registers all clear to 0. Effect is immediate, mid-press included.
//   Per button: 2-flop synchroniser -> debounce -> rising-edge detect.
//     - Debounce counter, width $clog2(DEBOUNCE_CYC): while synced != stable, increment;
//       when it reaches DEBOUNCE_CYC-1 and still differs, stable <= synced and counter <= 0.
//       Whenever synced == stable, counter <= 0 (glitch shorter than DEBOUNCE_CYC is dropped).
//     - Press event = 1-cycle pulse when stable goes 0->1. Release is debounced, no event.
//     - Holding a button produces exactly one event; no auto-repeat.
//   FSM (updates on the clock edge after the press-event cycle):
//     STOPPED: play -> PLAYING; stop ignored.
//     PLAYING: stop -> STOPPED; play -> PAUSED.
//     PAUSED : stop -> STOPPED; play -> PLAYING.
//     Both events in the same cycle: stop wins (STOPPED from PLAYING/PAUSED; in STOPPED,
//       play is taken -> PLAYING).
//     Illegal encoding 11 -> STOPPED on next clock, CLR=0.
//   Outputs are registered, loaded on the same edge as the state register:
//     START = (next_state != PLAYING).
//     CLR   = 1 for exactly one cycle on every transition into STOPPED from PLAYING or PAUSED,
//             and on the STOPPED->PLAYING transition; 0 otherwise (never on PAUSED<->PLAYING).
//   Latency from raw edge to output change: 2 (sync) + DEBOUNCE_CYC (debounce)
//     + 1 (edge detect) + 1 (state/output register) cycles, +/-1 for input phase.
// TESTING (benches use DEBOUNCE_CYC=4)
//   1 Reset: RST high, buttons toggling -> state=00, START=1, CLR=0 throughout; after
//     release, no event until a full debounced press.
//   2 BTN_PLAY high 20 cycles from STOPPED -> state 00->01 once, START 1->0, one CLR pulse;
//     no further transition while held.
//   3 From PLAYING, press PLAY -> state=10, START=1, CLR stays 0; press PLAY -> 01, START=0,
//     CLR stays 0.
//   4 From PAUSED, press STOP -> state=00, START=1, one-cycle CLR; press STOP again in
//     STOPPED -> no change, no CLR.
//   5 Glitch: BTN_PLAY high 3 cycles, or 0/1 bounce every 2 cycles for 30 cycles then low ->
//     no event, state unchanged.
//   6 Simultaneous debounced PLAY+STOP in PLAYING -> STOPPED with CLR; RST asserted during
//     debounce count -> counter cleared, no event after RST release until a new full press.

Source files
------------

// File: rtl/play_ctrl.sv
// Play/pause/stop control: debounces the PLAY and STOP buttons and runs the
// STOPPED/PLAYING/PAUSED machine that drives the downstream hold and restart pulse.
module play_ctrl #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_PLAY,
    input  logic       BTN_STOP,
    output logic       START,
    output logic       CLR,
    output logic [1:0] state
);

    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] ST_STOPPED = 2'b00;
    localparam logic [1:0] ST_PLAYING = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;

    // Bit 0 is PLAY, bit 1 is STOP throughout the input path.
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    stable_q;
    logic [1:0]    stable_prev_q;
    logic [CW-1:0] cnt_q [2];
    logic [1:0]    press;
    logic          play_ev;
    logic          stop_ev;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic          clr_d;
    logic          start_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {BTN_STOP, BTN_PLAY};
            sync2_q <= sync1_q;
        end
    end

    // A new level is accepted only after it has differed from the stable level
    // for DEBOUNCE_CYC consecutive cycles; any agreeing sample restarts the count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q      <= 2'b00;
            stable_prev_q <= 2'b00;
        end else begin
            stable_prev_q <= stable_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    stable_q[i] <= sync2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign press   = stable_q & ~stable_prev_q;
    assign play_ev = press[0];
    assign stop_ev = press[1];

    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            ST_STOPPED: begin
                if (play_ev) begin
                    state_d = ST_PLAYING;
                    clr_d   = 1'b1;
                end
            end
            ST_PLAYING: begin
                if (stop_ev) begin
                    state_d = ST_STOPPED;
                    clr_d   = 1'b1;
                end else if (play_ev) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (stop_ev) begin
                    state_d = ST_STOPPED;
                    clr_d   = 1'b1;
                end else if (play_ev) begin
                    state_d = ST_PLAYING;
                end
            end
            default: begin
                state_d = ST_STOPPED;
            end
        endcase
        start_d = (state_d != ST_PLAYING);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_STOPPED;
            START   <= 1'b1;
            CLR     <= 1'b0;
        end else begin
            state_q <= state_d;
            START   <= start_d;
            CLR     <= clr_d;
        end
    end

    assign state = state_q;

endmodule
